// File: rtl/imm_decode_stage_pkg.sv
// Shared definitions for the immediate-decode stage.
//   imm_type_t : tag describing which immediate format was decoded.
//   OPC_*      : RV32/RV64 base opcodes recognised by the decoder.
//   is_shift_f3: funct3 values that turn OP-IMM / OP-IMM-32 into shift-immediates.
package imm_decode_stage_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_SHAMT = 3'd2,
    IMM_S     = 3'd3,
    IMM_B     = 3'd4,
    IMM_U     = 3'd5,
    IMM_J     = 3'd6,
    IMM_Z     = 3'd7
  } imm_type_t;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_LOAD     = 7'b0000011;
  localparam opcode_t OPC_OP_IMM   = 7'b0010011;
  localparam opcode_t OPC_AUIPC    = 7'b0010111;
  localparam opcode_t OPC_OP_IMM32 = 7'b0011011;
  localparam opcode_t OPC_STORE    = 7'b0100011;
  localparam opcode_t OPC_OP       = 7'b0110011;
  localparam opcode_t OPC_LUI      = 7'b0110111;
  localparam opcode_t OPC_OP32     = 7'b0111011;
  localparam opcode_t OPC_BRANCH   = 7'b1100011;
  localparam opcode_t OPC_JALR     = 7'b1100111;
  localparam opcode_t OPC_JAL      = 7'b1101111;
  localparam opcode_t OPC_SYSTEM   = 7'b1110011;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode_stage_comb.sv
// Purely combinational immediate decoder.
//   instr_i   : raw 32-bit instruction
//   imm_o     : sign/zero-extended immediate, XLEN bits
//   type_o    : immediate format tag
//   illegal_o : opcode not supported for this XLEN / ZICSR_EN
module imm_decode_stage_comb
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ZICSR_EN = 1
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_t       type_o,
  output logic            illegal_o
);

  localparam bit IS_RV64 = (XLEN == 64);

  opcode_t     opcode;
  logic [2:0]  funct3;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Size casts of $signed() values sign-extend from instr[31] to XLEN.
  always_comb begin
    imm_o     = '0;
    type_o    = IMM_NONE;
    illegal_o = 1'b0;
    unique case (opcode)
      OPC_LOAD, OPC_JALR: begin
        imm_o  = XLEN'($signed(instr_i[31:20]));
        type_o = IMM_I;
      end
      OPC_OP_IMM: begin
        if (is_shift_f3(funct3)) begin
          // RV64 shifts carry a 6-bit shamt; RV32 only 5.
          imm_o  = IS_RV64 ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
          type_o = IMM_SHAMT;
        end else begin
          imm_o  = XLEN'($signed(instr_i[31:20]));
          type_o = IMM_I;
        end
      end
      OPC_OP_IMM32: begin
        if (!IS_RV64) begin
          illegal_o = 1'b1;
        end else if (is_shift_f3(funct3)) begin
          imm_o  = XLEN'(instr_i[24:20]);
          type_o = IMM_SHAMT;
        end else begin
          imm_o  = XLEN'($signed(instr_i[31:20]));
          type_o = IMM_I;
        end
      end
      OPC_STORE: begin
        imm_o  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        type_o = IMM_S;
      end
      OPC_BRANCH: begin
        imm_o  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                instr_i[11:8], 1'b0}));
        type_o = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_o  = XLEN'($signed({instr_i[31:12], 12'b0}));
        type_o = IMM_U;
      end
      OPC_JAL: begin
        imm_o  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                instr_i[30:21], 1'b0}));
        type_o = IMM_J;
      end
      OPC_SYSTEM: begin
        if ((ZICSR_EN != 0) && funct3[2]) begin
          imm_o  = XLEN'(instr_i[19:15]);
          type_o = IMM_Z;
        end
      end
      OPC_OP: begin
        // R-type: no immediate.
      end
      OPC_OP32: begin
        illegal_o = !IS_RV64;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer.
//   clk_i / reset_i     : clock, asynchronous active-high reset
//   flush_i             : squash every held entry (input of the same cycle dropped)
//   in_valid_i/in_ready_o, in_instr_i, in_pc_i          : upstream handshake + payload
//   out_valid_o/out_ready_i, out_imm_o, out_imm_type_o,
//   out_illegal_o, out_instr_o, out_pc_o                : downstream handshake + payload
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ZICSR_EN = 1,
  parameter int SKID_EN  = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_instr_i,
  input  logic [XLEN-1:0] in_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_imm_o,
  output imm_type_t       out_imm_type_o,
  output logic            out_illegal_o,
  output logic [31:0]     out_instr_o,
  output logic [XLEN-1:0] out_pc_o
);

  // Payload layout: {imm, type, illegal, instr, pc}
  localparam int PW = 2 * XLEN + 36;

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            dec_illegal;
  logic [PW-1:0]   in_payload;

  imm_decode_stage_comb #(.XLEN(XLEN), .ZICSR_EN(ZICSR_EN)) u_comb (
    .instr_i  (in_instr_i),
    .imm_o    (dec_imm),
    .type_o   (dec_type),
    .illegal_o(dec_illegal)
  );

  assign in_payload = {dec_imm, dec_type, dec_illegal, in_instr_i, in_pc_i};

  logic          alive_q;      // low only during the reset cycle, keeps in_ready low then
  logic          main_valid_q, main_valid_d;
  logic [PW-1:0] main_q,       main_d;
  logic          skid_full_q,  skid_full_d;
  logic [PW-1:0] skid_q,       skid_d;
  logic          accept, drain;

  assign in_ready_o  = alive_q & ((SKID_EN != 0) ? !skid_full_q
                                                 : (!main_valid_q | out_ready_i));
  assign out_valid_o = main_valid_q;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_full_d  = skid_full_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_full_d  = 1'b0;
    end else if (skid_full_q) begin
      // in_ready is low here, so only the drain side can move.
      if (drain) begin
        main_d      = skid_q;
        skid_full_d = 1'b0;
      end
    end else if (!main_valid_q || drain) begin
      // Main slot free (or freeing): new entry goes straight to main.
      if (accept) begin
        main_d       = in_payload;
        main_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main stalled: park the new entry in the skid slot.
      if (SKID_EN != 0) begin
        skid_d      = in_payload;
        skid_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alive_q      <= 1'b0;
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_full_q  <= 1'b0;
      skid_q       <= '0;
    end else begin
      alive_q      <= 1'b1;
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_full_q  <= skid_full_d;
      skid_q       <= skid_d;
    end
  end

  assign out_pc_o       = main_q[XLEN-1:0];
  assign out_instr_o    = main_q[XLEN+31:XLEN];
  assign out_illegal_o  = main_q[XLEN+32];
  assign out_imm_type_o = imm_type_t'(main_q[XLEN+35:XLEN+33]);
  assign out_imm_o      = main_q[PW-1:XLEN+36];

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three instances (RV32, RV64, RV32 without Zicsr)
// share one stimulus stream; a queue model of the stage and an arithmetic
// decoder predict every output on each falling edge.
module tb_imm_decode_stage;
  import imm_decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  always #5 clk = ~clk;

  // DUT outputs
  logic        rdy32, rdy64, rdynz, vld32, vld64, vldnz;
  logic [31:0] imm32, immnz, ins32, ins64, insnz, pc32, pcnz;
  logic [63:0] imm64, pc64;
  imm_type_t   typ32, typ64, typnz;
  logic        ill32, ill64, illnz;

  imm_decode_stage #(.XLEN(32), .ZICSR_EN(1), .SKID_EN(1)) dut32 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy32), .in_instr_i(in_instr), .in_pc_i(in_pc[31:0]),
    .out_valid_o(vld32), .out_ready_i(out_ready), .out_imm_o(imm32),
    .out_imm_type_o(typ32), .out_illegal_o(ill32), .out_instr_o(ins32), .out_pc_o(pc32));

  imm_decode_stage #(.XLEN(64), .ZICSR_EN(1), .SKID_EN(1)) dut64 (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdy64), .in_instr_i(in_instr), .in_pc_i(in_pc),
    .out_valid_o(vld64), .out_ready_i(out_ready), .out_imm_o(imm64),
    .out_imm_type_o(typ64), .out_illegal_o(ill64), .out_instr_o(ins64), .out_pc_o(pc64));

  imm_decode_stage #(.XLEN(32), .ZICSR_EN(0), .SKID_EN(1)) dutnz (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(rdynz), .in_instr_i(in_instr), .in_pc_i(in_pc[31:0]),
    .out_valid_o(vldnz), .out_ready_i(out_ready), .out_imm_o(immnz),
    .out_imm_type_o(typnz), .out_illegal_o(illnz), .out_instr_o(insnz), .out_pc_o(pcnz));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Immediate rules written as integer arithmetic on the instruction word.
  function automatic void model_dec(input logic [31:0] ins, input bit x64, input bit zc,
                                    output logic [63:0] imm, output imm_type_t t,
                                    output bit ill);
    longint s, sg, hi;
    logic [2:0] f3;
    bit shift;
    s     = longint'($signed(ins));
    sg    = s >>> 31;                 // all ones when instr[31]=1
    f3    = ins[14:12];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    imm = 64'd0; t = IMM_NONE; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h67: begin imm = 64'(s >>> 20); t = IMM_I; end
      7'h13: if (shift) begin
               imm = x64 ? 64'((ins >> 20) & 32'd63) : 64'((ins >> 20) & 32'd31);
               t = IMM_SHAMT;
             end else begin imm = 64'(s >>> 20); t = IMM_I; end
      7'h1B: if (!x64) ill = 1'b1;
             else if (shift) begin imm = 64'((ins >> 20) & 32'd31); t = IMM_SHAMT; end
             else begin imm = 64'(s >>> 20); t = IMM_I; end
      7'h23: begin
               hi  = s >>> 25;
               imm = 64'(hi << 5) | 64'((ins >> 7) & 32'd31); t = IMM_S;
             end
      7'h63: begin
               imm = 64'(sg << 12) | (64'(ins[7]) << 11) | 64'(((ins >> 25) & 32'd63) << 5)
                   | 64'(((ins >> 8) & 32'd15) << 1);
               t = IMM_B;
             end
      7'h37, 7'h17: begin imm = 64'(s); imm[11:0] = 12'd0; t = IMM_U; end
      7'h6F: begin
               imm = 64'(sg << 20) | 64'(((ins >> 12) & 32'd255) << 12) | (64'(ins[20]) << 11)
                   | 64'(((ins >> 21) & 32'd1023) << 1);
               t = IMM_J;
             end
      7'h73: if (zc && f3[2]) begin imm = 64'((ins >> 15) & 32'd31); t = IMM_Z; end
      7'h33: ;
      7'h3B: ill = !x64;
      default: ill = 1'b1;
    endcase
    if (!x64) imm = imm & 64'hFFFF_FFFF;
  endfunction

  // Stage model: a FIFO of accepted entries with room for two.
  typedef struct { logic [31:0] instr; logic [63:0] pc; } ent_t;
  ent_t q[$];
  bit   m_alive = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_alive = 1'b0;
    end else begin
      bit acc, drn;
      ent_t e;
      acc = in_valid && m_alive && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (flush) q.delete();
      else begin
        if (drn) begin
          $display("xfer out instr=%h pc=%h", q[0].instr, q[0].pc);
          void'(q.pop_front());
        end
        if (acc) begin e.instr = in_instr; e.pc = in_pc; q.push_back(e); end
      end
      m_alive = 1'b1;
    end
  end

  task automatic chk_dut(input string nm, input bit x64, input bit zc,
                         input logic vld, input logic rdy, input logic [63:0] imm,
                         input imm_type_t t, input logic ill, input logic [31:0] ins,
                         input logic [63:0] pc);
    logic [63:0] e_imm, e_pc;
    imm_type_t   e_t;
    bit          e_ill;
    chk({nm, ".out_valid"}, 64'(vld), 64'(q.size() > 0));
    chk({nm, ".in_ready"},  64'(rdy), 64'(m_alive && q.size() < 2));
    if (q.size() > 0) begin
      model_dec(q[0].instr, x64, zc, e_imm, e_t, e_ill);
      e_pc = x64 ? q[0].pc : (q[0].pc & 64'hFFFF_FFFF);
      chk({nm, ".imm"},   imm, e_imm);
      chk({nm, ".type"},  64'(t), 64'(e_t));
      chk({nm, ".ill"},   64'(ill), 64'(e_ill));
      chk({nm, ".instr"}, 64'(ins), 64'(q[0].instr));
      chk({nm, ".pc"},    pc, e_pc);
    end
  endtask

  always @(negedge clk) begin
    chk_dut("dut32", 1'b0, 1'b1, vld32, rdy32, 64'(imm32), typ32, ill32, ins32, 64'(pc32));
    chk_dut("dut64", 1'b1, 1'b1, vld64, rdy64, imm64, typ64, ill64, ins64, pc64);
    chk_dut("dutnz", 1'b0, 1'b0, vldnz, rdynz, 64'(immnz), typnz, illnz, insnz, 64'(pcnz));
  end

  logic [63:0] pc_cnt = 64'h0000_0001_0000_1000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc_cnt;
    pc_cnt   = pc_cnt + 64'd4;
  endtask

  task automatic send(input logic [31:0] ins);
    drive(ins);
    tick();
    in_valid = 1'b0;
  endtask

  logic [6:0] ops [14] = '{7'h03, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                           7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h7F, 7'h0B};

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 64'd0;
    tick(); tick();
    chk("rst.out_valid", 64'(vld32), 64'd0);
    chk("rst.in_ready",  64'(rdy32), 64'd0);
    chk("rst.imm",       imm64, 64'd0);
    chk("rst.instr",     64'(ins32), 64'd0);
    chk("rst.pc",        pc64, 64'd0);
    chk("rst.illegal",   64'(ill32), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst.in_ready", 64'(rdy32), 64'd1);

    // Literal decode results
    out_ready = 1'b1;
    send(32'hFE000EE3);
    chk("beq.imm",  64'(imm32), 64'hFFFF_FFFC);
    chk("beq.type", 64'(typ32), 64'(IMM_B));
    send(32'h800000B7);
    chk("lui64.imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lui32.imm", 64'(imm32), 64'h8000_0000);
    send(32'h0010009B);
    chk("addiw32.ill", 64'(ill32), 64'd1);
    chk("addiw32.imm", 64'(imm32), 64'd0);
    chk("addiw64.imm", imm64, 64'd1);
    chk("addiw64.ill", 64'(ill64), 64'd0);
    send(32'h3401D073);
    chk("csrrwi.imm",    64'(imm32), 64'd3);
    chk("csrrwi.type",   64'(typ32), 64'(IMM_Z));
    chk("csrrwi_nz.imm", 64'(immnz), 64'd0);
    chk("csrrwi_nz.type", 64'(typnz), 64'(IMM_NONE));
    tick();

    // Back-pressure: three back-to-back entries, sink stalled
    out_ready = 1'b0;
    drive(32'h00100093); tick();
    chk("bp.ready_after_1", 64'(rdy32), 64'd1);
    drive(32'h00200113); tick();
    chk("bp.ready_after_2", 64'(rdy32), 64'd0);
    drive(32'h00300193); tick();
    chk("bp.hold_first", 64'(ins32), 64'h00100093);
    out_ready = 1'b1; tick();
    chk("bp.second", 64'(ins32), 64'h00200113);
    chk("bp.ready_again", 64'(rdy32), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp.third", 64'(ins32), 64'h00300193);
    tick();
    chk("bp.empty", 64'(vld32), 64'd0);

    // Flush with both slots full and a live input
    out_ready = 1'b0;
    drive(32'h00400213); tick();
    drive(32'h00500293); tick();
    drive(32'h00600313); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.out_valid", 64'(vld32), 64'd0);
    chk("flush.in_ready",  64'(rdy32), 64'd1);
    out_ready = 1'b1; tick();
    chk("flush.nothing", 64'(vld32), 64'd0);

    // Random stream with random back-pressure, occasional flush, one mid-stream reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = {r[31:7], ops[$urandom_range(0, 13)]};
      in_pc     = pc_cnt; pc_cnt = pc_cnt + 64'd4;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      if (i == 200) begin
        reset = 1'b1;
        #1;
        chk("midrst.out_valid32", 64'(vld32), 64'd0);
        chk("midrst.out_valid64", 64'(vld64), 64'd0);
        tick();
        reset = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("final.empty", 64'(vld32), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
